// File: rtl/pheromone_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aco_pkg
//  Description : Shared types and constants for the ACO pheromone update
//                path: mesh geometry, pheromone value type, update-queue
//                entry, update FSM states and the destination-row helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aco_pkg;

    localparam int X_NODES = 4;                 // mesh width
    localparam int Y_NODES = 4;                 // mesh height
    localparam int N       = 5;                 // router ports, 0 = local
    localparam int PH_W    = 4;                 // pheromone value width
    localparam int NODES   = X_NODES * Y_NODES; // rows in the table

    localparam int XW     = $clog2(X_NODES);
    localparam int YW     = $clog2(Y_NODES);
    localparam int PORT_W = $clog2(N);
    localparam int ROW_W  = $clog2(NODES);

    typedef logic [PH_W-1:0] ph_t;

    // One queued update: which port the backward ant came in on, and the
    // table row (destination node) it refers to.
    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [ROW_W-1:0]  l_dest;
    } upd_entry_t;

    localparam int UPD_ENTRY_W = $bits(upd_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } fsm_state_t;

    // Row index of a destination node: y * X_NODES + x.
    function automatic logic [ROW_W-1:0] calc_l_dest(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        return ROW_W'(y) * ROW_W'(X_NODES) + ROW_W'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pheromone_update_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aco_upd_fifo
//  Description : Synchronous FIFO for queued pheromone updates. Read data is
//                the head entry (show-ahead); push and pop may occur in the
//                same cycle. Pushes when full and pops when empty are ignored.
//  Ports       : clk, reset_n (sync, active-low)
//                i_push / i_din  - write side
//                i_pop  / o_dout - read side, o_dout valid while !o_empty
//                o_full, o_empty - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module aco_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pheromone_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pheromone_update_ctrl
//  Description : Single writer of the per-router ACO pheromone table.
//                Round-robin arbitration of backward-ant update requests,
//                a small update queue, and a 3-state IDLE/CALC/WRITE
//                read-modify-write engine that reinforces the entry of the
//                arrival port and decays all the others (saturating).
//                Optional macro PH_EVAPORATE_EN adds periodic evaporation
//                that sweeps the rows while no update is pending.
//  Ports       : clk, reset_n (sync, active-low)
//                i_upd_valid  [N]            update request per port
//                i_upd_x_dest [N][XW]        destination x per port
//                i_upd_y_dest [N][YW]        destination y per port
//                o_upd_ready  [N]            grant (transfer = valid & ready)
//                o_pheromones [NODES][N-1]   full table, straight from regs
//                o_busy                      queue non-empty or FSM not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module pheromone_update_ctrl
    import aco_pkg::*;
#(
`ifdef PH_EVAPORATE_EN
    parameter int EVAP_PERIOD = 64,
`endif
    parameter int PH_MAX     = 15,
    parameter int PH_MIN     = 0,
    parameter int PH_INIT    = 0,
    parameter int PH_INC     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [N-1:0]                         i_upd_valid,
    input  logic [N-1:0][XW-1:0]                 i_upd_x_dest,
    input  logic [N-1:0][YW-1:0]                 i_upd_y_dest,
    output logic [N-1:0]                         o_upd_ready,
    output logic [NODES-1:0][N-2:0][PH_W-1:0]    o_pheromones,
    output logic                                 o_busy
);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    ph_t [NODES-1:0][N-2:0] r_table;
    fsm_state_t             r_state;
    fsm_state_t             w_state_nxt;
    upd_entry_t             r_op;
    ph_t [N-2:0]            r_wr_row;
    ph_t [N-2:0]            w_cur_row;
    ph_t [N-2:0]            w_new_row;
    logic [PH_W:0]          w_sum;

    logic [PORT_W-1:0]      r_rr_ptr;
    logic [PORT_W-1:0]      w_grant_idx;
    logic                   w_grant_vld;
    logic [N-1:0]           w_grant;

    upd_entry_t             w_push_entry;
    logic [UPD_ENTRY_W-1:0] w_fifo_dout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_pop;

`ifdef PH_EVAPORATE_EN
    localparam int EVAP_TW = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;

    logic [EVAP_TW-1:0]     r_evap_timer;
    logic                   r_evap_pend;
    logic [ROW_W-1:0]       r_sweep_ptr;
    logic                   w_evap_start;
`endif

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    function automatic logic [PORT_W-1:0] rr_index(
        input logic [PORT_W-1:0] base,
        input int                k
    );
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return PORT_W'(s);
    endfunction

    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_grant_vld && i_upd_valid[rr_index(r_rr_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = rr_index(r_rr_ptr, k);
            end
        end
        // Ready must be low throughout reset, regardless of requests.
        if (w_fifo_full || !reset_n) begin
            w_grant_vld = 1'b0;
        end
        if (w_grant_vld) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign o_upd_ready = w_grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            r_rr_ptr <= (w_grant_idx == PORT_W'(N-1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Update queue
    // ------------------------------------------------------------------
    assign w_push_entry.port   = w_grant_idx;
    assign w_push_entry.l_dest = calc_l_dest(i_upd_x_dest[w_grant_idx],
                                             i_upd_y_dest[w_grant_idx]);

    aco_upd_fifo #(
        .WIDTH (UPD_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_grant_vld),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Update FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
`ifdef PH_EVAPORATE_EN
        w_evap_start = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // Queued updates always win over a pending evaporation.
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_CALC;
                end
`ifdef PH_EVAPORATE_EN
                else if (r_evap_pend) begin
                    w_evap_start = 1'b1;
                    w_state_nxt  = ST_CALC;
                end
`endif
            end
            ST_CALC:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = !w_fifo_empty || (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Row update: reinforce entry port-1, decay the rest. Port 0 matches
    // no entry, so it (and evaporation, which reuses port 0) decays all.
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_row = r_table[r_op.l_dest];
        w_new_row = w_cur_row;
        w_sum     = '0;
        for (int j = 0; j < N-1; j++) begin
            if (r_op.port == PORT_W'(j+1)) begin
                w_sum = {1'b0, w_cur_row[j]} + (PH_W+1)'(PH_INC);
                if (w_sum > (PH_W+1)'(PH_MAX)) begin
                    w_new_row[j] = ph_t'(PH_MAX);
                end else begin
                    w_new_row[j] = w_sum[PH_W-1:0];
                end
            end else begin
                if (w_cur_row[j] > ph_t'(PH_MIN)) begin
                    w_new_row[j] = w_cur_row[j] - ph_t'(1);
                end else begin
                    w_new_row[j] = ph_t'(PH_MIN);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op     <= '0;
            r_wr_row <= '0;
            for (int r = 0; r < NODES; r++) begin
                for (int j = 0; j < N-1; j++) begin
                    r_table[r][j] <= ph_t'(PH_INIT);
                end
            end
        end else begin
            if (w_pop) begin
                r_op <= upd_entry_t'(w_fifo_dout);
            end
`ifdef PH_EVAPORATE_EN
            else if (w_evap_start) begin
                r_op.port   <= '0;
                r_op.l_dest <= r_sweep_ptr;
            end
`endif
            if (r_state == ST_CALC) begin
                r_wr_row <= w_new_row;
            end
            if (r_state == ST_WRITE) begin
                r_table[r_op.l_dest] <= r_wr_row;
            end
        end
    end

    assign o_pheromones = r_table;

`ifdef PH_EVAPORATE_EN
    // ------------------------------------------------------------------
    // Evaporation timer and row sweep. The pending flag stays set until
    // the FSM is free to take it, so no step is dropped under traffic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_evap_timer <= '0;
            r_evap_pend  <= 1'b0;
            r_sweep_ptr  <= '0;
        end else begin
            if (r_evap_timer == EVAP_TW'(EVAP_PERIOD-1)) begin
                r_evap_timer <= '0;
                r_evap_pend  <= 1'b1;
            end else begin
                r_evap_timer <= r_evap_timer + 1'b1;
                if (w_evap_start) begin
                    r_evap_pend <= 1'b0;
                end
            end
            if (w_evap_start) begin
                r_sweep_ptr <= (r_sweep_ptr == ROW_W'(NODES-1)) ? '0
                                                                : r_sweep_ptr + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pheromone_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pheromone_update_ctrl
//  Description : Directed self-checking bench for pheromone_update_ctrl.
//                A second instance with PH_INIT = 3 provides the preloaded
//                table for the port-0 decay case. With PH_EVAPORATE_EN the
//                evaporation sequence runs instead of the update sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pheromone_update_ctrl;
    import aco_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              reset_n;
    logic [N-1:0]                      valid, valid2, rdy, rdy2;
    logic [N-1:0][XW-1:0]              xd, xd2;
    logic [N-1:0][YW-1:0]              yd, yd2;
    logic [NODES-1:0][N-2:0][PH_W-1:0] pher, pher2, gold;
    logic                              busy, busy2;

    int n_pass  = 0;
    int n_total = 0;

    pheromone_update_ctrl #(
`ifdef PH_EVAPORATE_EN
        .EVAP_PERIOD (8),
`endif
        .PH_INIT     (0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_upd_valid  (valid),
        .i_upd_x_dest (xd),
        .i_upd_y_dest (yd),
        .o_upd_ready  (rdy),
        .o_pheromones (pher),
        .o_busy       (busy)
    );

    pheromone_update_ctrl #(
`ifdef PH_EVAPORATE_EN
        .EVAP_PERIOD (64),
`endif
        .PH_INIT     (3)
    ) dut_i3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_upd_valid  (valid2),
        .i_upd_x_dest (xd2),
        .i_upd_y_dest (yd2),
        .o_upd_ready  (rdy2),
        .o_pheromones (pher2),
        .o_busy       (busy2)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden row update: saturating reinforce of entry port-1, decay others.
    task automatic gold_apply(input int port, input int row);
        for (int j = 0; j < N-1; j++) begin
            if (j + 1 == port) begin
                if (gold[row][j] < 4'd15) gold[row][j] = gold[row][j] + 4'd1;
            end else begin
                if (gold[row][j] > 4'd0) gold[row][j] = gold[row][j] - 4'd1;
            end
        end
    endtask

    task automatic send(input bit which, input int p, input int x, input int y);
        int n;
        if (which) begin
            valid2 = '0; valid2[p] = 1'b1; xd2[p] = XW'(x); yd2[p] = YW'(y);
        end else begin
            valid = '0; valid[p] = 1'b1; xd[p] = XW'(x); yd[p] = YW'(y);
        end
        #1;
        n = 0;
        while (((which ? rdy2[p] : rdy[p]) == 1'b0) && n < 20) begin
            tick(); #1; n++;
        end
        check("send_grant", 256'(which ? rdy2[p] : rdy[p]), 256'(1));
        @(posedge clk); #1;
        valid  = '0;
        valid2 = '0;
    endtask

    task automatic wait_idle(input bit which);
        int n;
        n = 0;
        while ((which ? busy2 : busy) && n < 50) begin
            tick(); n++;
        end
        check("wait_idle", 256'(which ? busy2 : busy), 256'(0));
    endtask

    task automatic wait_busy(input logic v);
        int n;
        n = 0;
        while (busy !== v && n < 40) begin
            tick(); n++;
        end
        check("wait_busy", 256'(busy), 256'(v));
    endtask

    logic [N-1:0] exp_rdy [12] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                   5'b00010, 5'b00100, 5'b00000, 5'b00000,
                                   5'b01000, 5'b00000, 5'b00000, 5'b10000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        valid = '0; valid2 = '0;
        xd = '0; yd = '0; xd2 = '0; yd2 = '0;
        gold = '0;
        tick(); tick();
        check("rst_ready", 256'(rdy), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_table", 256'(pher), 256'(0));
        check("rst_table_i3", 256'(pher2), {64{4'h3}});
        reset_n = 1'b1;

`ifdef PH_EVAPORATE_EN
        // Build row 0 = {2,0,0,0}, then watch the sweep decay it.
        send(0, 1, 0, 0);
        wait_idle(0);
        send(0, 1, 0, 0);
        wait_idle(0);
        check("evap_pre_row0", 256'(pher[0]), 256'(16'h0002));
        wait_busy(1'b1);
        wait_busy(1'b0);
        gold[0][0] = 4'd1;
        check("evap_first_step", 256'(pher), 256'(gold));
        // Second step lands on row 1, leaving row 0 untouched.
        wait_busy(1'b1);
        wait_busy(1'b0);
        check("evap_sweep_row1", 256'(pher[0]), 256'(16'h0001));
        // Rows 2..15 then wrap back to row 0.
        for (int s = 0; s < 15; s++) begin
            wait_busy(1'b1);
            wait_busy(1'b0);
        end
        check("evap_wrap_row0", 256'(pher[0]), 256'(16'h0000));
`else
        // ---- Single update: port 2, dest (1,2) -> row 9 entry 1
        valid[2] = 1'b1; xd[2] = 2'd1; yd[2] = 2'd2;
        #1;
        check("t1_ready", 256'(rdy), 256'(5'b00100));
        tick();
        valid = '0;
        check("t1_busy_t1", 256'(busy), 256'(1));
        tick();
        check("t1_busy_t2", 256'(busy), 256'(1));
        tick();
        check("t1_busy_t3", 256'(busy), 256'(1));
        check("t1_table_t3", 256'(pher), 256'(0));
        tick();
        check("t1_row9", 256'(pher[9]), 256'(16'h0010));
        check("t1_busy_t4", 256'(busy), 256'(0));
        gold_apply(2, 9);
        check("t1_table", 256'(pher), 256'(gold));

        // ---- Saturation: 20 updates, port 1, dest (0,0)
        for (int i = 1; i <= 20; i++) begin
            send(0, 1, 0, 0);
            wait_idle(0);
            gold_apply(1, 0);
            if (i == 14) check("sat_14", 256'(pher[0]), 256'(16'h000E));
            if (i == 15) check("sat_15", 256'(pher[0]), 256'(16'h000F));
        end
        check("sat_20", 256'(pher[0]), 256'(16'h000F));
        check("sat_table", 256'(pher), 256'(gold));

        // ---- Port 0 update decays every entry of row 0
        send(0, 0, 0, 0);
        wait_idle(0);
        check("p0_row0", 256'(pher[0]), 256'(16'h000E));
        gold_apply(0, 0);

        // ---- Contention: ports 1..4 valid every cycle
        valid = 5'b11110;
        xd[1] = 2'd0; xd[2] = 2'd0; xd[3] = 2'd1; xd[4] = 2'd1;
        yd[1] = 2'd3; yd[2] = 2'd3; yd[3] = 2'd3; yd[4] = 2'd3;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("cont_rdy_c%0d", c), 256'(rdy), 256'(exp_rdy[c]));
            for (int p = 1; p < N; p++) begin
                if (exp_rdy[c][p]) gold_apply(p, (p <= 2) ? 12 : 13);
            end
            tick();
        end
        valid = '0;
        wait_idle(0);
        check("cont_table", 256'(pher), 256'(gold));

        // ---- Reset in CALC with 3 entries queued
        valid = 5'b01110;
        for (int p = 1; p <= 3; p++) begin
            xd[p] = 2'd2; yd[p] = 2'd2;
        end
        for (int c = 0; c < 5; c++) tick();
        #1;
        check("rst_mid_busy", 256'(busy), 256'(1));
        reset_n = 1'b0;
        #1;
        check("rst_mid_ready", 256'(rdy), 256'(0));
        tick();
        check("rst_mid_ready_held", 256'(rdy), 256'(0));
        check("rst_mid_busy_after", 256'(busy), 256'(0));
        check("rst_mid_table", 256'(pher), 256'(0));
        valid   = '0;
        reset_n = 1'b1;
        tick(); tick(); tick(); tick();
        check("rst_mid_quiet_busy", 256'(busy), 256'(0));
        check("rst_mid_quiet_table", 256'(pher), 256'(0));

        // ---- Preloaded decay on PH_INIT = 3 instance
        send(1, 0, 1, 1);
        wait_idle(1);
        check("i3_row5", 256'(pher2[5]), 256'(16'h2222));
        check("i3_row4", 256'(pher2[4]), 256'(16'h3333));
        send(1, 3, 1, 1);
        wait_idle(1);
        check("i3_row5_p3", 256'(pher2[5]), 256'(16'h1311));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pheromone_update_ctrl.md
# pheromone_update_ctrl

Owns the per-router ACO pheromone table and is its single writer. Backward-ant update requests arrive on the router's N input ports. The block arbitrates them, queues them in a small FIFO, and applies reinforce/decay read-modify-writes row by row. All rows are exposed on combinational read ports for the route selector, which only reads the table.

## Interface
- X_NODES, 4, mesh width
- Y_NODES, 4, mesh height
- N, 5, router ports; port 0 = local, ports 1..N-1 = neighbours; table entry j ↔ port j+1
- PH_W, 4, pheromone value width
- PH_MAX, 15, saturation ceiling
- PH_MIN, 0, floor
- PH_INIT, 0, value of every entry after reset
- PH_INC, 1, reinforcement step
- FIFO_DEPTH, 4, update queue depth (power of two)
- EVAP_PERIOD, 64, cycles between evaporation steps (used only with PH_EVAPORATE_EN)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- i_upd_valid  in  [N]  backward-ant update request per port
- i_upd_x_dest  in  [N][clog2(X_NODES)]  destination x of the ant
- i_upd_y_dest  in  [N][clog2(Y_NODES)]  destination y of the ant
- o_upd_ready  out  [N]  grant; transfer occurs when valid & ready
- o_pheromones  out  [NODES][N-1][PH_W]  full table, driven directly from registers
- o_busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE

## Operation
- NODES = X_NODES*Y_NODES. Row index l_dest = y*X_NODES + x.
- Arbiter: round-robin over i_upd_valid; at most one grant per cycle; no grant while the FIFO is full.
  - o_upd_ready depends combinationally on i_upd_valid.
  - The RR pointer moves to granted+1 mod N.
- FIFO entry is {port, l_dest}. Push and pop in the same cycle are legal. When full, all o_upd_ready are 0.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the op register and go to CALC.
  - CALC: read row op.l_dest and compute the new row into the wr_row register. Go to WRITE.
  - WRITE: commit wr_row to the table. Go to IDLE.
- Update rule for entry j:
  - If j+1 == port: min(v+PH_INC, PH_MAX).
  - Otherwise: max(v-1, PH_MIN).
  - Port 0 updates therefore decay all entries.
  - Arithmetic is done at PH_W+1 bits, then clamped. No wrap-around is ever allowed.
- Throughput: one update per 3 cycles. Bursts are absorbed by the FIFO; back-pressure comes only through o_upd_ready.
- Reset: table = PH_INIT; FIFO empty; FSM = IDLE; RR pointer = 0; evaporation timer and sweep pointer = 0. All outputs at reset: o_upd_ready = 0, o_busy = 0, o_pheromones = PH_INIT.
- Reset mid-operation discards queued and in-flight updates. No partial row write occurs.

## Timing
- Accept at cycle t. FIFO entry at t+1. Pop at t+1 if IDLE. CALC at t+2. WRITE at t+3. New value visible on o_pheromones at t+4.
- Back-to-back updates to the same row are serialised by the FSM. The second update always sees the first one's result (no hazard).
- o_pheromones changes only on the clock edge that ends a WRITE (or an evaporation write).

## Configuration
- PH_EVAPORATE_EN defined:
  - Timer counts to EVAP_PERIOD-1 and then sets evap_pend.
  - When the FSM is IDLE and the FIFO is empty, the row at the sweep pointer is decayed by 1 (floor PH_MIN) through CALC/WRITE.
  - Sweep pointer wraps NODES-1→0.
  - Updates always have priority; evap_pend is held, not lost, while updates are pending.
- PH_EVAPORATE_EN undefined: no timer; the table changes only on updates.

## Structure
- Package aco_pkg:
  - PH_W and the ph_t value type
  - the upd_entry_t {port, l_dest} struct
  - the FSM state enum
  - NODES
  - the l_dest computation function
- Sub-module aco_upd_fifo: synchronous FIFO, parameterised width/depth, with full/empty flags.
- Arbiter, FSM and table stay in pheromone_update_ctrl.

## Test plan
- Single update:
  - Stimulus: port 2, dest (1,2), i.e. row 9.
  - Response: at t+4, row 9 = {0,1,0,0}; all other rows stay 0; o_busy high t+1..t+3.
- Saturation:
  - Stimulus: 20 sequential updates on port 1, dest (0,0).
  - Response: row 0 entry 0 = 15 and never wraps; entries 1–3 stay 0.
- Contention and back-pressure:
  - Stimulus: ports 1–4 valid every cycle.
  - Response: grants in order 1,2,3,4,1,…; o_upd_ready all 0 once the FIFO holds 4; no request lost; final table matches the golden model.
- Port 0 decay:
  - Stimulus: preload row 5 = {3,3,3,3}, then update port 0, dest (1,1).
  - Response: row 5 = {2,2,2,2}.
- Reset mid-operation:
  - Stimulus: reset_n low during CALC with 3 entries queued.
  - Response: next cycle FSM IDLE, FIFO empty, all entries = PH_INIT, o_upd_ready = 0 while in reset.
- Evaporation (PH_EVAPORATE_EN):
  - Stimulus: EVAP_PERIOD = 8, row 0 = {2,0,0,0}, no traffic.
  - Response: row 0 = {1,0,0,0} after the first evaporation step; sweep reaches row 1 next.
